// File: rtl/sysarray_nxn.sv
// NxN output-stationary systolic array with skewed west/north feeds and a registered result read port.
// Define SYSARRAY_SIGNED_EN for two's-complement operands; by default operands are unsigned.
module sysarray_nxn #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int AW = 64,
    parameter int KW = 16,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] west_data,
    input  logic [N*DW-1:0] north_data,
    output logic            busy,
    output logic            done,
    input  logic            rd_en,
    input  logic [IW-1:0]   rd_row,
    input  logic [IW-1:0]   rd_col,
    output logic            rd_valid,
    output logic [AW-1:0]   rd_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [KW-1:0] beat_q, beat_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          accept;
    logic          clear;

    logic [DW-1:0] a_w   [N][N];
    logic [DW-1:0] b_w   [N][N];
    logic [AW-1:0] acc_w [N][N];

    assign in_ready = (state_q == S_FEED);
    assign busy     = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign accept   = in_valid & in_ready;
    assign clear    = start & ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        beat_d  = beat_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    klen_d  = k_len;
                    beat_d  = '0;
                    dcnt_d  = '0;
                    state_d = (k_len != '0) ? S_FEED : S_DRAIN;
                end
            end
            S_FEED: begin
                if (accept) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q + 1'b1 == klen_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Terminal count is held one cycle so the far corner's last add lands before done.
                if (dcnt_q == DRAIN_LAST) state_d = S_DONE;
                else dcnt_d = dcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            klen_q  <= '0;
            beat_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            dcnt_q  <= dcnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_wskew
        logic [DW-1:0] sk_q [0:i];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int d = 0; d <= i; d++) sk_q[d] <= '0;
            end else begin
                sk_q[0] <= accept ? west_data[i*DW +: DW] : '0;
                for (int d = 1; d <= i; d++) sk_q[d] <= sk_q[d-1];
            end
        end
        assign a_w[i][0] = sk_q[i];
    end

    for (genvar j = 0; j < N; j++) begin : g_nskew
        logic [DW-1:0] sk_q [0:j];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int d = 0; d <= j; d++) sk_q[d] <= '0;
            end else begin
                sk_q[0] <= accept ? north_data[j*DW +: DW] : '0;
                for (int d = 1; d <= j; d++) sk_q[d] <= sk_q[d-1];
            end
        end
        assign b_w[0][j] = sk_q[j];
    end

    for (genvar i = 0; i < N; i++) begin : g_r
        for (genvar j = 0; j < N; j++) begin : g_c
            logic [AW-1:0] acc_q;
            logic [AW-1:0] prod_x;
`ifdef SYSARRAY_SIGNED_EN
            logic signed [2*DW-1:0] prod;
            assign prod = $signed(a_w[i][j]) * $signed(b_w[i][j]);
`else
            logic [2*DW-1:0] prod;
            assign prod = a_w[i][j] * b_w[i][j];
`endif
            assign prod_x = AW'(prod);

            always_ff @(posedge clk or posedge rst) begin
                if (rst)        acc_q <= '0;
                else if (clear) acc_q <= '0;
                else            acc_q <= acc_q + prod_x;
            end
            assign acc_w[i][j] = acc_q;

            if (j < N - 1) begin : g_east
                logic [DW-1:0] a_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) a_q <= '0;
                    else     a_q <= a_w[i][j];
                end
                assign a_w[i][j+1] = a_q;
            end

            if (i < N - 1) begin : g_south
                logic [DW-1:0] b_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) b_q <= '0;
                    else     b_q <= b_w[i][j];
                end
                assign b_w[i+1][j] = b_q;
            end
        end
    end

    logic          rd_valid_q;
    logic [AW-1:0] rd_data_q;
    logic          idx_ok;

    assign idx_ok = ({1'b0, rd_row} < (IW+1)'(N)) && ({1'b0, rd_col} < (IW+1)'(N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= idx_ok ? acc_w[rd_row][rd_col] : '0;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_sysarray_nxn.sv
// Scoreboard bench for sysarray_nxn: matrix-product reference model, random jobs,
// bubbles, start-while-busy, k_len=0, out-of-range reads and mid-drain reset.
module tb_sysarray_nxn;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int KW   = 16;
    localparam int IW   = $clog2(N);
    localparam int KMAX = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [KW-1:0]   k_len;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] west_data;
    logic [N*DW-1:0] north_data;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [IW-1:0]   rd_row;
    logic [IW-1:0]   rd_col;
    logic            rd_valid;
    logic [AW-1:0]   rd_data;

    sysarray_nxn #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .west_data  (west_data),
        .north_data (north_data),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges++;

    int npass = 0;
    int ntot  = 0;

    logic [AW-1:0] exp_q [$];
    string         tag_q [$];
    logic [DW-1:0] am [KMAX][N];
    logic [DW-1:0] bm [KMAX][N];
    logic [AW-1:0] cm [N][N];
    int            last_edge;

    task automatic chk(string nm, longint act, longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", rd_valid, 0);
            end else begin
                chk(tag_q.pop_front(), rd_data, exp_q.pop_front());
            end
        end
    end

    function automatic longint mulop(logic [DW-1:0] a, logic [DW-1:0] b);
`ifdef SYSARRAY_SIGNED_EN
        return longint'($signed(a)) * longint'($signed(b));
`else
        return longint'(a) * longint'(b);
`endif
    endfunction

    // C[i][j] = sum over beats k of A[i][k]*B[k][j], reduced modulo 2^AW
    task automatic model(int kl);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                longint s = 0;
                for (int k = 0; k < kl; k++) s += mulop(am[k][i], bm[k][j]);
                cm[i][j] = AW'(s);
            end
    endtask

    task automatic fill_random();
        for (int k = 0; k < KMAX; k++)
            for (int i = 0; i < N; i++) begin
                am[k][i] = DW'($urandom);
                bm[k][i] = DW'($urandom);
            end
    endtask

    task automatic do_start(int k);
        k_len = KW'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: continuous, 1: alternate bubbles, 2: random bubbles
    task automatic feed(int k, int mode, bit poke);
        int beat = 0;
        int cyc  = 0;
        while (beat < k && cyc < 400) begin
            bit v;
            bit acc;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid = v;
            start    = poke && (cyc == 1);
            for (int i = 0; i < N; i++) begin
                west_data[i*DW +: DW]  = v ? am[beat][i] : DW'($urandom);
                north_data[i*DW +: DW] = v ? bm[beat][i] : DW'($urandom);
            end
            chk("in_ready_feed", in_ready, 1);
            acc = v && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                beat++;
                last_edge = edges;
            end
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("feed_beats", beat, k);
    endtask

    task automatic wait_done(string nm);
        int n = 0;
        chk("busy_drain", busy, 1);
        chk("in_ready_drain", in_ready, 0);
        chk("done_early", done, 0);
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, edges - last_edge, 2 * N);
        chk("busy_done", busy, 0);
    endtask

    task automatic rd_one(int r, int c, logic [AW-1:0] e, string nm);
        rd_en  = 1'b1;
        rd_row = IW'(r);
        rd_col = IW'(c);
        exp_q.push_back(e);
        tag_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic read_all(string nm);
        logic [AW-1:0] last = '0;
        if ((1 << IW) > N) begin
            rd_one(N, 0, '0, {nm, "_oor_row"});
            rd_one(0, N, '0, {nm, "_oor_col"});
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                rd_one(i, j, cm[i][j], $sformatf("%s_c%0d%0d", nm, i, j));
                last = cm[i][j];
            end
        rd_en = 1'b0;
        @(posedge clk); #1;
        chk("rd_valid_idle", rd_valid, 0);
        chk("rd_data_hold", rd_data, last);
    endtask

    task automatic job(int k, int mode, bit poke, string nm);
        model(k);
        do_start(k);
        if (k > 0) feed(k, mode, poke);
        else last_edge = edges;
        wait_done({nm, "_latency"});
        read_all(nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        k_len      = '0;
        in_valid   = 1'b0;
        west_data  = '0;
        north_data = '0;
        rd_en      = 1'b0;
        rd_row     = '0;
        rd_col     = '0;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) cm[i][j] = '0;
        read_all("idle");

        for (int k = 0; k < KMAX; k++)
            for (int i = 0; i < N; i++) begin
                am[k][i] = DW'(i * 3 + k + 1);
                bm[k][i] = DW'(k == i);
            end
        job(3, 0, 1'b0, "ident");
        job(3, 1, 1'b0, "ident_gap");
        job(0, 0, 1'b0, "klen0");

        for (int k = 0; k < KMAX; k++)
            for (int i = 0; i < N; i++) begin
                am[k][i] = '0;
                bm[k][i] = '0;
            end
        am[0][0] = 8'hFF;
        bm[0][0] = 8'h03;
        job(1, 0, 1'b0, "ffx03");

        for (int r = 0; r < 6; r++) begin
            fill_random();
            job($urandom_range(1, 12), $urandom_range(0, 2), r == 2, $sformatf("rnd%0d", r));
        end

        fill_random();
        do_start(4);
        feed(4, 0, 1'b0);
        rd_en  = 1'b1;
        rd_row = '0;
        rd_col = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) cm[i][j] = '0;
        read_all("post_rst");
        fill_random();
        job(5, 2, 1'b0, "after_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
